amm_dual_port_mem: RTL and testbench
====================================

Name: amm_dual_port_mem

Overview:
- Synthesizable Avalon-MM memory slave with one read port and one write port. It sits directly downstream of byte_inc and serves its amm_rd_* and amm_wr_* masters.
- Provides a fixed, programmable read latency, byte-enabled writes, and deterministic waitrequest throttling. Benches and FPGA top levels exercise byte_inc against real slave timing instead of a zero-wait stub.

Parameters:
- DATA_WIDTH, 64, word width in bits.
- ADDR_WIDTH, 10, word address width; depth is 2**ADDR_WIDTH words.
- BYTE_CNT, DATA_WIDTH/8, number of byteenable bits.
- READ_LATENCY, 2, cycles from accepted read to readdatavalid; legal range 1..8.
- MAX_PENDING, 2, maximum outstanding accepted reads; legal range 1..READ_LATENCY.
- RD_STALL_PERIOD, 0, read waitrequest pulses high 1 cycle in every N; 0 disables.
- WR_STALL_PERIOD, 0, same as above for the write port.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- amm_rd_address_i  in  ADDR_WIDTH  read word address.
- amm_rd_read_i  in  1  read request.
- amm_rd_readdata_o  out  DATA_WIDTH  read data.
- amm_rd_readdatavalid_o  out  1  readdata qualifier.
- amm_rd_waitrequest_o  out  1  read stall.
- amm_wr_address_i  in  ADDR_WIDTH  write word address.
- amm_wr_write_i  in  1  write request.
- amm_wr_writedata_i  in  DATA_WIDTH  write data.
- amm_wr_byteenable_i  in  BYTE_CNT  per-byte write enable.
- amm_wr_waitrequest_o  out  1  write stall.

Behaviour:
- Clocking/reset: one clock, clk_i. srst_i is synchronous, active-high.
- Reset values: readdatavalid_o=0, readdata_o=0, both waitrequest_o=1 while srst_i is high, pending count=0, stall counters=0, latency pipeline flushed. Memory contents are not reset.
- Read acceptance: a read is accepted in a cycle where read_i=1 and rd_waitrequest_o=0. Address is sampled at that edge.
- Read timing: exactly READ_LATENCY cycles after acceptance, readdatavalid_o=1 for 1 cycle with that word. Back-to-back accepts give back-to-back valids, in order.
- readdata_o holds its last value when readdatavalid_o=0.
- Pending count: +1 on accept, -1 on readdatavalid_o, unchanged when both occur in the same cycle. Never exceeds MAX_PENDING.
- rd_waitrequest_o = stall pulse OR (pending==MAX_PENDING AND no readdatavalid_o this cycle).
  - rd_waitrequest_o is combinational from registered state only; it does not depend on read_i.
- Write acceptance: a write is accepted when write_i=1 and wr_waitrequest_o=0. Only bytes with byteenable[i]=1 are updated. byteenable=0 is an accepted no-op.
- Same-cycle collision: an accepted read and an accepted write to the same address in the same edge is write-first. The read returns the merged new word.
- Read-after-write at a later cycle always sees the written data.
- Stall generator (per port): free-running counter 0..N-1, waitrequest pulse when counter==N-1. The counter advances every cycle regardless of traffic.
- Requests held under waitrequest must stay stable; the slave does not check this.
- Reset mid-operation: in-flight reads are dropped and no readdatavalid fires after reset. A write presented in the reset cycle is not committed.
- Addresses wrap naturally; no out-of-range case exists.
- Elaboration-time checks (generate-time error): READ_LATENCY out of range, MAX_PENDING out of range, DATA_WIDTH not a multiple of 8.

Decomposition:
- Shared package amm_mem_package: a data word typedef, a byteenable typedef, an address typedef (all parameterised by width), and a helper function merge_bytes(old, new, be) reused by the bench scoreboard.
- One sub-module, amm_stall_gen (PERIOD parameter, outputs stall), instantiated once per port.
- Memory array, latency shift pipeline and pending counter live in the top module.

Test Plan:
- Write 0x0123456789ABCDEF to addr 5 with be=0xFF, then read addr 5 -> readdatavalid exactly 2 cycles after accept, data 0x0123456789ABCDEF.
- Write 0xFFFF_FFFF_FFFF_FFFF to addr 5 with be=0x0F, then read -> 0x01234567FFFFFFFF.
- 8 back-to-back reads of addr 0..7 with MAX_PENDING=2 and READ_LATENCY=2 -> waitrequest never asserts (valid frees a slot each cycle), 8 in-order valids.
- With READ_LATENCY=4 and MAX_PENDING=2 -> waitrequest high after 2 accepts, 2 stall cycles, then a third accept.
- Same-cycle write of 0xAA..AA (be=0xFF) and read of addr 9 -> read returns 0xAA..AA. With RD_STALL_PERIOD=4 -> rd_waitrequest high exactly every 4th cycle.
- Assert srst_i for 1 cycle with 2 reads in flight -> no readdatavalid afterwards, waitrequest high during reset. A full byte_inc run over base 16, length 40 against this slave -> memory equals the initial contents with each byte +1.

Source files
------------

// File: rtl/amm_mem_package.sv
// Shared types and helpers for the Avalon-MM dual-port memory slave.
// Containers are sized for the widest supported word; each instance narrows
// them to its own DATA_WIDTH/BYTE_CNT with size casts.
package amm_mem_package;

  localparam int AMM_MAX_DATA_WIDTH = 1024;
  localparam int AMM_MAX_BYTE_CNT   = AMM_MAX_DATA_WIDTH / 8;
  localparam int AMM_MAX_ADDR_WIDTH = 32;

  typedef logic [AMM_MAX_DATA_WIDTH-1:0] amm_data_t;
  typedef logic [AMM_MAX_BYTE_CNT-1:0]   amm_be_t;
  typedef logic [AMM_MAX_ADDR_WIDTH-1:0] amm_addr_t;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic amm_data_t merge_bytes(input amm_data_t old_word,
                                            input amm_data_t new_word,
                                            input amm_be_t   be);
    amm_data_t merged;
    merged = old_word;
    for (int i = 0; i < AMM_MAX_BYTE_CNT; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/amm_dual_port_mem_stall_gen.sv
// Periodic waitrequest pulse generator: one high cycle in every PERIOD.
// Latency: registered counter, output decoded combinationally from it.
// Backpressure: none; free-running regardless of traffic, PERIOD=0 disables.
module amm_stall_gen #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic srst,
  output logic stall
);

  localparam int            CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST   = CW'((PERIOD > 0) ? PERIOD - 1 : 0);
  localparam bit            ENABLE = (PERIOD > 0);

  logic [CW-1:0] cnt;

  // Count 0..PERIOD-1 and wrap; with PERIOD=0 the counter simply sits at 0.
  always_ff @(posedge clk) begin
    if (srst || cnt == LAST) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign stall = ENABLE && (cnt == LAST);

endmodule

// File: rtl/amm_dual_port_mem.sv
// Avalon-MM memory slave: one read port, one byte-enabled write port.
// Latency: readdatavalid exactly READ_LATENCY cycles after an accepted read.
// Backpressure: waitrequest from periodic stall pulses and a pending-read cap.
module amm_dual_port_mem
  import amm_mem_package::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 10,
  parameter int BYTE_CNT        = DATA_WIDTH / 8,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_PENDING     = 2,
  parameter int RD_STALL_PERIOD = 0,
  parameter int WR_STALL_PERIOD = 0
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
  input  logic                  amm_rd_read_i,
  output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
  output logic                  amm_rd_readdatavalid_o,
  output logic                  amm_rd_waitrequest_o,
  input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
  input  logic                  amm_wr_write_i,
  input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
  output logic                  amm_wr_waitrequest_o
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("amm_dual_port_mem: READ_LATENCY must be in 1..8");
    end
    if (MAX_PENDING < 1 || MAX_PENDING > READ_LATENCY) begin : g_bad_pending
      $error("amm_dual_port_mem: MAX_PENDING must be in 1..READ_LATENCY");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > AMM_MAX_DATA_WIDTH) begin : g_bad_width
      $error("amm_dual_port_mem: DATA_WIDTH must be a multiple of 8 within package limits");
    end
    if (BYTE_CNT != DATA_WIDTH / 8) begin : g_bad_bytes
      $error("amm_dual_port_mem: BYTE_CNT must equal DATA_WIDTH/8");
    end
  endgenerate

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam int                PEND_W    = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                   mem [DEPTH];
  logic                    rd_stall;
  logic                    wr_stall;
  logic                    rd_acc;
  logic                    wr_acc;
  word_t                   wr_word;
  word_t                   rd_word;
  logic [READ_LATENCY-1:0] pipe_vld;
  word_t                   pipe_dat [READ_LATENCY];
  logic [PEND_W-1:0]       pend_cnt;

  amm_stall_gen #(.PERIOD(RD_STALL_PERIOD)) u_rd_stall (
    .clk   (clk_i),
    .srst  (srst_i),
    .stall (rd_stall)
  );

  amm_stall_gen #(.PERIOD(WR_STALL_PERIOD)) u_wr_stall (
    .clk   (clk_i),
    .srst  (srst_i),
    .stall (wr_stall)
  );

  // A returning read frees its slot in the same cycle, so a full counter
  // only stalls when nothing is coming back.
  assign amm_rd_waitrequest_o = srst_i | rd_stall |
                                ((pend_cnt == PEND_FULL) & ~amm_rd_readdatavalid_o);
  assign amm_wr_waitrequest_o = srst_i | wr_stall;

  assign rd_acc = amm_rd_read_i  & ~amm_rd_waitrequest_o;
  assign wr_acc = amm_wr_write_i & ~amm_wr_waitrequest_o;

  // Merged write word, and write-first read data on a same-address collision.
  always_comb begin
    wr_word = word_t'(merge_bytes(amm_data_t'(mem[amm_wr_address_i]),
                                  amm_data_t'(amm_wr_writedata_i),
                                  amm_be_t'(amm_wr_byteenable_i)));
    rd_word = mem[amm_rd_address_i];
    if (wr_acc && (amm_wr_address_i == amm_rd_address_i)) rd_word = wr_word;
  end

  // Commit accepted writes; memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[amm_wr_address_i] <= wr_word;
  end

  // Latency pipeline; data stages only load behind a valid, so the last
  // stage holds the most recently returned word between valids.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_dat[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign amm_rd_readdatavalid_o = pipe_vld[READ_LATENCY-1];
  assign amm_rd_readdata_o      = pipe_dat[READ_LATENCY-1];

  // Outstanding-read counter: +1 on accept, -1 on return.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_cnt <= '0;
    end else begin
      case ({rd_acc, amm_rd_readdatavalid_o})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_amm_dual_port_mem.sv
// Bench for amm_dual_port_mem: directed scenarios plus random traffic,
// all checked every cycle against a queue/array model of the slave.
module tb_amm_dual_port_mem;
  import amm_mem_package::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BC = DW / 8;
  localparam int L  = 3;
  localparam int MP = 2;
  localparam int RP = 5;
  localparam int WP = 7;

  logic          clk = 1'b0;
  logic          srst_i;
  logic [AW-1:0] amm_rd_address_i;
  logic          amm_rd_read_i;
  logic [DW-1:0] amm_rd_readdata_o;
  logic          amm_rd_readdatavalid_o;
  logic          amm_rd_waitrequest_o;
  logic [AW-1:0] amm_wr_address_i;
  logic          amm_wr_write_i;
  logic [DW-1:0] amm_wr_writedata_i;
  logic [BC-1:0] amm_wr_byteenable_i;
  logic          amm_wr_waitrequest_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  amm_dual_port_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC), .READ_LATENCY(L),
    .MAX_PENDING(MP), .RD_STALL_PERIOD(RP), .WR_STALL_PERIOD(WP)
  ) dut (
    .clk_i                  (clk),
    .srst_i                 (srst_i),
    .amm_rd_address_i       (amm_rd_address_i),
    .amm_rd_read_i          (amm_rd_read_i),
    .amm_rd_readdata_o      (amm_rd_readdata_o),
    .amm_rd_readdatavalid_o (amm_rd_readdatavalid_o),
    .amm_rd_waitrequest_o   (amm_rd_waitrequest_o),
    .amm_wr_address_i       (amm_wr_address_i),
    .amm_wr_write_i         (amm_wr_write_i),
    .amm_wr_writedata_i     (amm_wr_writedata_i),
    .amm_wr_byteenable_i    (amm_wr_byteenable_i),
    .amm_wr_waitrequest_o   (amm_wr_waitrequest_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [63:0] v;
    v = 64'h1111_1111_1111_1111 * 64'(i + 1);
    return v ^ 64'h0F0F_0000_0000_F0F0;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    int          due;
    logic [63:0] dat;
  } rd_t;

  rd_t         rq[$];
  logic [63:0] mmem [0:(1<<AW)-1];
  logic [63:0] last_dat = '0;
  int          cyc = 0;
  int          since_rst = 0;
  amm_data_t   mw;

  always begin : cmp
    logic ev, erw, eww, er_st;
    @(negedge clk);
    #2;
    if (srst_i) begin
      chk("rst_rd_wait", 64'(amm_rd_waitrequest_o), 64'd1);
      chk("rst_wr_wait", 64'(amm_wr_waitrequest_o), 64'd1);
      rq.delete();
      last_dat  = '0;
      since_rst = 0;
    end else begin
      er_st = (since_rst % RP) == RP - 1;
      ev    = (rq.size() > 0) && (rq[0].due == cyc);
      erw   = er_st || (rq.size() >= MP && !ev);
      eww   = (since_rst % WP) == WP - 1;
      chk("rd_wait", 64'(amm_rd_waitrequest_o), 64'(erw));
      chk("wr_wait", 64'(amm_wr_waitrequest_o), 64'(eww));
      chk("rd_valid", 64'(amm_rd_readdatavalid_o), 64'(ev));
      if (ev) begin
        last_dat = rq[0].dat;
        void'(rq.pop_front());
      end
      chk("rd_data", amm_rd_readdata_o, last_dat);
      if (amm_wr_write_i && !eww) begin
        mw = merge_bytes(amm_data_t'(mmem[amm_wr_address_i]),
                         amm_data_t'(amm_wr_writedata_i),
                         amm_be_t'(amm_wr_byteenable_i));
        mmem[amm_wr_address_i] = mw[63:0];
      end
      if (amm_rd_read_i && !erw) rq.push_back('{cyc + L, mmem[amm_rd_address_i]});
      since_rst++;
    end
    cyc++;
  end

  // Collects returned words for the directed scenarios.
  logic [63:0] rx_q[$];
  always begin : collect
    @(negedge clk);
    #2;
    if (!srst_i && amm_rd_readdatavalid_o) rx_q.push_back(amm_rd_readdata_o);
  end

  // ---------------- driver helpers ----------------
  task automatic wait_free(input bit rd, input bit wr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if ((!rd || !amm_rd_waitrequest_o) && (!wr || !amm_wr_waitrequest_o)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("handshake");
  endtask

  task automatic do_write(input int a, input logic [63:0] d, input logic [7:0] be);
    wait_free(1'b0, 1'b1);
    amm_wr_address_i    = AW'(a);
    amm_wr_writedata_i  = d;
    amm_wr_byteenable_i = be;
    amm_wr_write_i      = 1'b1;
    @(posedge clk);
    #1;
    amm_wr_write_i = 1'b0;
  endtask

  task automatic do_read(input int a);
    wait_free(1'b1, 1'b0);
    amm_rd_address_i = AW'(a);
    amm_rd_read_i    = 1'b1;
    @(posedge clk);
    #1;
    amm_rd_read_i = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string nm);
    for (int i = 0; i < 64; i++) begin
      if (rx_q.size() >= n) return;
      @(negedge clk);
      #3;
    end
    if (rx_q.size() < n) timeout_fail(nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin : drive
    int          lat;
    int          nrd;
    int          nwr;
    amm_data_t   mp;
    srst_i              = 1'b1;
    amm_rd_address_i    = '0;
    amm_rd_read_i       = 1'b0;
    amm_wr_address_i    = '0;
    amm_wr_write_i      = 1'b0;
    amm_wr_writedata_i  = '0;
    amm_wr_byteenable_i = '0;
    repeat (3) @(posedge clk);
    #1;
    srst_i = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_valid", 64'(amm_rd_readdatavalid_o), 64'd0);
    chk("reset_data", amm_rd_readdata_o, 64'd0);

    mp = merge_bytes(amm_data_t'(64'h1122_3344_5566_7788),
                     amm_data_t'(64'hAAAA_AAAA_AAAA_AAAA), amm_be_t'(8'b1000_0001));
    chk("merge_pin", mp[63:0], 64'hAA22_3344_5566_77AA);

    // Full write then read: latency and data.
    do_write(5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rx_q.delete();
    do_read(5);
    lat = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #3;
      if (rx_q.size() > 0) begin
        lat = k;
        break;
      end
    end
    chk("rd_latency", 64'(lat), 64'(L));
    wait_rx(1, "full_read");
    if (rx_q.size() > 0) chk("full_read", rx_q[0], 64'h0123_4567_89AB_CDEF);

    // Partial byte-enable write.
    do_write(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rx_q.delete();
    do_read(5);
    wait_rx(1, "partial_read");
    if (rx_q.size() > 0) chk("partial_read", rx_q[0], 64'h0123_4567_FFFF_FFFF);

    // byteenable=0 is a no-op.
    do_write(5, 64'h0, 8'h00);
    rx_q.delete();
    do_read(5);
    wait_rx(1, "be_zero_read");
    if (rx_q.size() > 0) chk("be_zero_read", rx_q[0], 64'h0123_4567_FFFF_FFFF);

    // Fill the random-traffic region.
    for (int i = 0; i < 32; i++) do_write(i, pat(i), 8'hFF);

    // Streamed reads come back in order.
    rx_q.delete();
    for (int i = 0; i < 8; i++) do_read(i);
    wait_rx(8, "stream_reads");
    for (int i = 0; i < 8 && i < rx_q.size(); i++) chk("stream_order", rx_q[i], pat(i));

    // Same-cycle write and read of one address: write-first.
    rx_q.delete();
    wait_free(1'b1, 1'b1);
    amm_wr_address_i    = AW'(9);
    amm_wr_writedata_i  = 64'hAAAA_AAAA_AAAA_AAAA;
    amm_wr_byteenable_i = 8'hFF;
    amm_wr_write_i      = 1'b1;
    amm_rd_address_i    = AW'(9);
    amm_rd_read_i       = 1'b1;
    @(posedge clk);
    #1;
    amm_wr_write_i = 1'b0;
    amm_rd_read_i  = 1'b0;
    wait_rx(1, "collision");
    if (rx_q.size() > 0) chk("collision", rx_q[0], 64'hAAAA_AAAA_AAAA_AAAA);

    // Idle bus: stall pulses occur once per period on each port.
    nrd = 0;
    nwr = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      #1;
      nrd += int'(amm_rd_waitrequest_o);
      nwr += int'(amm_wr_waitrequest_o);
    end
    chk("rd_stall_count", 64'(nrd), 64'd7);
    chk("wr_stall_count", 64'(nwr), 64'd5);

    // Reset with two reads in flight: both are dropped.
    do_read(1);
    do_read(2);
    srst_i = 1'b1;
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    rx_q.delete();
    repeat (10) @(posedge clk);
    chk("post_reset_valids", 64'(rx_q.size()), 64'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      srst_i              = ($urandom_range(0, 199) == 0);
      amm_rd_read_i       = 1'($urandom_range(0, 1));
      amm_rd_address_i    = AW'($urandom_range(0, 31));
      amm_wr_write_i      = 1'($urandom_range(0, 1));
      amm_wr_address_i    = AW'($urandom_range(0, 31));
      amm_wr_writedata_i  = {$urandom, $urandom};
      amm_wr_byteenable_i = 8'($urandom);
    end
    @(posedge clk);
    #1;
    srst_i         = 1'b0;
    amm_rd_read_i  = 1'b0;
    amm_wr_write_i = 1'b0;
    repeat (12) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
